// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the PC, reads the instruction memory
// and buffers (pc, instr) pairs in a small FIFO for decode.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter int          PC_STEP  = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  output logic [31:0]                imem_addr,
  input  logic [31:0]                imem_dout,
  input  logic                       fetch_en,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  output logic                       if_valid,
  input  logic                       if_ready,
  output logic [31:0]                if_instr,
  output logic [31:0]                if_pc,
  output logic [$clog2(DEPTH):0]     if_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic {BOOT, RUN} state_t;

  state_t          state;
  logic [31:0]     pc;
  logic [31:0]     instr_q [DEPTH];
  logic [31:0]     pc_q    [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;
  logic            deq;
  logic            enq;

  assign imem_addr = {2'b00, pc[31:2]};
  assign if_valid  = (count != '0);
  assign if_count  = count;
  assign if_instr  = instr_q[rd_ptr];
  assign if_pc     = pc_q[rd_ptr];

  assign deq = if_valid & if_ready;
  assign enq = (state == RUN) & fetch_en & ~redirect_valid
             & ((count < CW'(DEPTH)) | deq);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= BOOT;
      pc     <= RESET_PC & ~32'd3;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        pc_q[i]    <= '0;
      end
    end else begin
      state <= RUN;
      if (redirect_valid) begin
        // a concurrent deq has already been consumed; the rest is dropped
        pc     <= redirect_pc & ~32'd3;
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) begin
          instr_q[wr_ptr] <= imem_dout;
          pc_q[wr_ptr]    <= pc;
          wr_ptr          <= wr_ptr + 1'b1;
          pc              <= pc + 32'(PC_STEP);
        end
        if (deq) rd_ptr <= rd_ptr + 1'b1;
        unique case (1'b1)
          enq & ~deq: count <= count + 1'b1;
          deq & ~enq: count <= count - 1'b1;
          default:    count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus random traffic
// against a queue-based reference model.
module tb_ifetch_unit;

  localparam logic [31:0] RPC0 = 32'h0000_0000;
  localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;
  localparam int          DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_en = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        if_ready = 1'b1;

  logic [31:0] imem_addr, imem_dout, if_instr, if_pc;
  logic        if_valid;
  logic [1:0]  if_count;

  logic [31:0] imem_addr1, imem_dout1, if_instr1, if_pc1;
  logic        if_valid1;
  logic [1:0]  if_count1;

  logic [31:0] mem [32];

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] q[$];
  logic [31:0] m_pc;
  bit          m_boot;
  logic [31:0] saved;

  always #5 clk = ~clk;

  assign imem_dout  = mem[imem_addr[4:0]];
  assign imem_dout1 = mem[imem_addr1[4:0]];

  ifetch_unit #(.RESET_PC(RPC0), .DEPTH(DEPTH), .PC_STEP(4)) u0 (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_dout(imem_dout),
    .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_instr(if_instr), .if_pc(if_pc), .if_count(if_count)
  );

  ifetch_unit #(.RESET_PC(RPC1), .DEPTH(DEPTH), .PC_STEP(4)) u1 (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr1), .imem_dout(imem_dout1),
    .fetch_en(fetch_en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .if_valid(if_valid1), .if_ready(if_ready),
    .if_instr(if_instr1), .if_pc(if_pc1), .if_count(if_count1)
  );

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: the FIFO is a queue of {pc, instr}; the PC is a byte counter.
  task automatic cyc();
    bit deq;
    bit enq;
    if (!rst_n) begin
      q.delete();
      m_pc = RPC0 & ~32'd3;
      m_boot = 1'b1;
    end else begin
      deq = (q.size() != 0) && if_ready;
      enq = !m_boot && fetch_en && !redirect_valid
            && ((q.size() < DEPTH) || deq);
      if (deq) void'(q.pop_front());
      if (redirect_valid) begin
        q.delete();
        m_pc = redirect_pc & ~32'd3;
      end else if (enq) begin
        q.push_back({m_pc, mem[m_pc[6:2]]});
        m_pc = m_pc + 32'd4;
      end
      m_boot = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("valid", 32'(if_valid), 32'(q.size() != 0));
    chk("count", 32'(if_count), 32'(q.size()));
    chk("addr", imem_addr, m_pc >> 2);
    if (q.size() != 0) begin
      chk("pc", if_pc, q[0][63:32]);
      chk("instr", if_instr, q[0][31:0]);
    end
  endtask

  initial begin
    for (int k = 0; k < 32; k++) mem[k] = 32'h1000 + 32'(k);

    // reset, then stream
    cyc();
    chk("rst_valid", 32'(if_valid), 32'd0);
    chk("rst_instr", if_instr, 32'd0);
    chk("rst_pc", if_pc, 32'd0);
    chk("rst_addr1", imem_addr1, 32'h3FFF_FFFE);
    rst_n = 1'b1;
    cyc();
    chk("boot_valid", 32'(if_valid), 32'd0);
    cyc();
    chk("first_valid", 32'(if_valid), 32'd1);
    chk("first_pc", if_pc, 32'd0);
    chk("first_instr", if_instr, 32'h1000);
    chk("wrap_pc0", if_pc1, 32'hFFFF_FFF8);
    chk("wrap_instr0", if_instr1, 32'h101E);
    cyc();
    chk("wrap_pc1", if_pc1, 32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr1, 32'd0);
    cyc();
    chk("wrap_pc2", if_pc1, 32'd0);
    chk("stream_pc8", if_pc, 32'd8);

    // backpressure
    if_ready = 1'b0;
    repeat (5) cyc();
    chk("bp_count", 32'(if_count), 32'd2);
    chk("bp_addr", imem_addr, 32'd4);
    chk("bp_head", if_pc, 32'd8);
    chk("bp_instr", if_instr, 32'h1002);
    if_ready = 1'b1;
    cyc();
    chk("resume1", if_pc, 32'd12);
    cyc();
    chk("resume2", if_pc, 32'd16);

    // redirect while full, with a handshake in the same cycle
    if_ready = 1'b0;
    cyc();
    if_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0042;
    cyc();
    redirect_valid = 1'b0;
    chk("redir_valid", 32'(if_valid), 32'd0);
    chk("redir_count", 32'(if_count), 32'd0);
    chk("redir_addr", imem_addr, 32'd16);
    cyc();
    chk("redir_pc", if_pc, 32'h40);
    chk("redir_instr", if_instr, 32'h1010);

    // fetch disable drains
    if_ready = 1'b0;
    repeat (2) cyc();
    fetch_en = 1'b0;
    if_ready = 1'b1;
    saved = imem_addr;
    repeat (2) cyc();
    chk("drain_valid", 32'(if_valid), 32'd0);
    chk("drain_addr", imem_addr, saved);
    fetch_en = 1'b1;
    cyc();
    chk("reen_pc", if_pc, saved << 2);

    // reset mid-stream with FIFO full
    if_ready = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b0;
    cyc();
    chk("mrst_count", 32'(if_count), 32'd0);
    chk("mrst_addr", imem_addr, 32'd0);
    rst_n = 1'b1;
    if_ready = 1'b1;
    cyc();
    chk("mrst_boot", 32'(if_valid), 32'd0);
    cyc();
    chk("mrst_refetch", if_pc, 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      fetch_en = ($urandom_range(0, 9) < 8);
      if_ready = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc = $urandom;
      rst_n = ($urandom_range(0, 99) != 0);
      cyc();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Instruction fetch stage; sits directly upstream of the 32-entry word-indexed instruction memory.
- Owns the program counter and drives the memory word address.
- Captures the memory's combinational read data together with its PC into a small FIFO.
- Presents instructions to decode over a valid/ready handshake; supports branch redirect with flush and a fetch-enable gate.

Parameters:
- RESET_PC, 32'h0000_0000, byte address of the first fetch after reset (bits [1:0] ignored).
- DEPTH, 2, fetch FIFO entries (power of two, ≥2).
- PC_STEP, 4, byte increment per sequential fetch.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous, active-low reset.
- imem_addr  output  32  word address to instruction memory, equal to {2'b00, pc[31:2]}.
- imem_dout  input  32  instruction word from memory; combinational read of imem_addr, valid in the same cycle.
- fetch_en  input  1  when low, no new fetches; FIFO still drains.
- redirect_valid  input  1  branch/jump taken; flush and restart at redirect_pc.
- redirect_pc  input  32  redirect target byte address; bits [1:0] forced to 0.
- if_valid  output  1  FIFO head holds a valid instruction.
- if_ready  input  1  decode accepts the head this cycle.
- if_instr  output  32  head instruction word.
- if_pc  output  32  byte PC of head instruction.
- if_count  output  $clog2(DEPTH)+1  current FIFO occupancy, for debug and bench.

Behaviour:
- Reset is synchronous and active-low, on clk: rst_n low at a rising edge applies reset.
- Reset values: pc=RESET_PC&~3; state=BOOT; FIFO empty; if_valid=0, if_instr=0, if_pc=0, if_count=0.
- imem_addr is combinational from pc, so it is RESET_PC>>2 during reset.
- States:
  - BOOT: entered on reset; lasts exactly one cycle after rst_n high, with no fetch; then goes to RUN.
  - RUN: normal operation.
- deq = if_valid & if_ready. Transfer completes on that edge; head pops.
- enq = (state==RUN) & fetch_en & ~redirect_valid & ((count<DEPTH) | deq).
  - On enq: push {pc, imem_dout}; pc <= pc + PC_STEP, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
- No enq: pc holds (unless redirected).
- count update: +1 on enq only, −1 on deq only, unchanged on both or neither.
- Full FIFO with deq in the same cycle: enq allowed (throughput 1/cycle at full).
- Latency:
  - Instruction fetched in cycle N appears on if_valid/if_instr/if_pc in cycle N+1 (registered FIFO output).
  - First if_valid is high in the 2nd cycle after reset release (BOOT, then fetch).
- if_instr and if_pc must hold stable while if_valid & ~if_ready (no change under backpressure).
- redirect_valid=1 at an edge:
  - The current-cycle deq, if any, still completes (consumer took it).
  - All remaining FIFO entries are discarded; count <= 0.
  - No enq that cycle; pc <= redirect_pc & ~3.
  - if_valid=0 the next cycle; the target instruction is fetched that next cycle and is valid one cycle later. Redirect-to-valid latency is 2 cycles.
- Redirect while fetch_en=0: pc is updated; the FIFO is flushed; fetch resumes from the new pc once fetch_en=1.
- Back-to-back redirects: the last one wins; each flushes.
- Redirect during BOOT: pc is updated; BOOT still completes its cycle.
- Reset asserted mid-operation: all state returns to reset values at that edge regardless of other inputs; in-flight entries are lost.
- FIFO never overflows or underflows; deq on empty is impossible (if_valid=0).
- imem_dout is sampled only on enq; an X on imem_dout when no enq occurs must not propagate.

Test Plan:
- Reset release, RESET_PC=0, fetch_en=1, if_ready=1, memory word k = 32'h1000+k:
  - if_valid rises 2 cycles after release.
  - Streams (pc, instr) = (0,1000),(4,1001),(8,1002)… one per cycle; imem_addr = 0,1,2….
- if_ready=0 for 5 cycles from pc=8:
  - if_count saturates at 2; imem_addr stops at 4.
  - Head stays (8,1002).
  - On if_ready=1, outputs resume (12,1003),(16,1004) with no gap or duplicate.
- Redirect to 32'h0000_0042 while FIFO holds 2:
  - Next cycle if_valid=0 and if_count=0; imem_addr=16.
  - One cycle later the head is (0x40,1010).
  - Any if_ready handshake in the redirect cycle is counted exactly once.
- fetch_en=0 with FIFO full, if_ready=1:
  - Drains 2 entries, then if_valid=0; pc is unchanged.
  - Re-enable gives the next sequential pc one cycle later.
- RESET_PC=32'hFFFF_FFF8: PCs FFFF_FFF8, FFFF_FFFC, 0000_0000; imem_addr wraps to 0.
- rst_n low for one edge mid-stream with the FIFO full: next cycle if_valid=0, if_count=0, pc=RESET_PC; the BOOT cycle is observed before refetch.
